disp_scan_ctrl: RTL and testbench



---
 rtl/disp_pkg.sv | 18 +
 rtl/seg7_decode.sv | 11 +
 rtl/disp_scan_ctrl.sv | 165 ++++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Glyphs are active-low, bit0 = segment a.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        BLANK = 2'd2
    } state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-low 7-segment pattern, purely combinational.
module seg7_decode
    import disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_GLYPH[nibble_i];

endmodule

// File: rtl/disp_scan_ctrl.sv
// Scan scheduler sharing one segment bus across NUM_DIGITS digits with a blank slot
// between digits; new content is held pending and committed only at frame boundaries.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int TICK_DIV    = 12500,
    parameter int ON_TICKS    = 3,
    parameter int BLANK_TICKS = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    en,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    input  logic [NUM_DIGITS-1:0]   load_mask,
    output logic                    load_ready,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done,
    output logic                    busy
);

    localparam int SLOT_MAX = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
    localparam int SW       = $clog2(SLOT_MAX + 1);
    localparam int IW       = $clog2(NUM_DIGITS);
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_e                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic [SW-1:0]           slot_q, slot_d;
    logic [4*NUM_DIGITS-1:0] sh_data_q, pd_data_q;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_mask_q, pd_dp_q, pd_mask_q;
    logic                    pend_full_q;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    tick, commit, accept;
    logic [3:0]              nib_sel;
    logic [6:0]              glyph;

    assign nib_sel = sh_data_q[4*idx_q +: 4];

    seg7_decode u_dec (
        .nibble_i (nib_sel),
        .seg_o    (glyph)
    );

    assign tick       = (state_q != IDLE) && (presc_q == PW'(TICK_DIV - 1));
    assign accept     = load_valid && !pend_full_q;
    assign load_ready = !pend_full_q;
    assign busy       = (state_q != IDLE);
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        slot_d     = slot_q;
        presc_d    = (state_q == IDLE || tick) ? '0 : presc_q + 1'b1;
        commit     = 1'b0;
        frame_done = 1'b0;
        an_d       = '1;
        seg_d      = SEG_OFF;
        dp_d       = 1'b1;

        if (state_q == DRIVE) begin
            an_d[idx_q] = ~sh_mask_q[idx_q];
            seg_d       = glyph;
            dp_d        = ~sh_dp_q[idx_q];
        end

        // Disable wins over everything: drop to IDLE with all counters cleared.
        if (!en) begin
            state_d = IDLE;
            idx_d   = '0;
            slot_d  = '0;
            presc_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    commit  = pend_full_q;
                    state_d = DRIVE;
                    idx_d   = '0;
                    slot_d  = '0;
                    presc_d = '0;
                end
                DRIVE: begin
                    if (tick) begin
                        if (slot_q == SW'(ON_TICKS - 1)) begin
                            slot_d  = '0;
                            state_d = BLANK;
                        end else begin
                            slot_d = slot_q + 1'b1;
                        end
                    end
                end
                BLANK: begin
                    if (tick) begin
                        if (slot_q == SW'(BLANK_TICKS - 1)) begin
                            slot_d  = '0;
                            state_d = DRIVE;
                            if (idx_q == IW'(NUM_DIGITS - 1)) begin
                                idx_d      = '0;
                                frame_done = 1'b1;
                                commit     = pend_full_q;
                            end else begin
                                idx_d = idx_q + 1'b1;
                            end
                        end else begin
                            slot_d = slot_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            presc_q     <= '0;
            slot_q      <= '0;
            sh_data_q   <= '0;
            sh_dp_q     <= '0;
            sh_mask_q   <= '0;
            pd_data_q   <= '0;
            pd_dp_q     <= '0;
            pd_mask_q   <= '0;
            pend_full_q <= 1'b0;
            an_q        <= '1;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            presc_q <= presc_d;
            slot_q  <= slot_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            if (commit) begin
                sh_data_q <= pd_data_q;
                sh_dp_q   <= pd_dp_q;
                sh_mask_q <= pd_mask_q;
            end
            // Commit only happens with pending full, accept only with it empty.
            if (commit) begin
                pend_full_q <= 1'b0;
            end else if (accept) begin
                pd_data_q   <= load_data;
                pd_dp_q     <= load_dp;
                pd_mask_q   <= load_mask;
                pend_full_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: directed scenarios plus random traffic, all checked
// against a frame-time reference model.
module tb_disp_scan_ctrl;

    localparam int ND      = 4;
    localparam int TD      = 4;
    localparam int ON      = 3;
    localparam int BL      = 1;
    localparam int DIGIT_P = (ON + BL) * TD;
    localparam int DRIVE_P = ON * TD;
    localparam int FRAME   = ND * DIGIT_P;

    logic        clk = 1'b0;
    logic        rstn, en, load_valid;
    logic [15:0] load_data;
    logic [3:0]  load_dp, load_mask;
    logic        load_ready, dp, frame_done, busy;
    logic [3:0]  an;
    logic [6:0]  seg;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    disp_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .TICK_DIV    (TD),
        .ON_TICKS    (ON),
        .BLANK_TICKS (BL)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_dp    (load_dp),
        .load_mask  (load_mask),
        .load_ready (load_ready),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done),
        .busy       (busy)
    );

    // Active-high glyphs (gfedcba); the display itself is active-low.
    function automatic logic [6:0] glyph_on(input logic [3:0] h);
        case (h)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Model: m_t counts cycles since the start of the current frame.
    bit          m_active, m_full;
    int          m_t;
    logic [15:0] m_sd, m_pd;
    logic [3:0]  m_sdp, m_smk, m_pdp, m_pmk;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;

    always @(posedge clk) begin : model
        int d;
        bit comm, acc;
        if (!rstn) begin
            m_active = 0; m_full = 0; m_t = 0;
            m_sd = '0; m_sdp = '0; m_smk = '0;
            m_pd = '0; m_pdp = '0; m_pmk = '0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            d = m_t / DIGIT_P;
            if (m_active && (m_t % DIGIT_P) < DRIVE_P) begin
                e_an  = m_smk[d] ? ~(4'b0001 << d) : 4'hF;
                e_seg = ~glyph_on(m_sd[d*4 +: 4]);
                e_dp  = ~m_sdp[d];
            end else begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end
            acc  = load_valid && !m_full;
            comm = 0;
            if (!en) begin
                m_active = 0; m_t = 0;
            end else if (!m_active) begin
                comm = m_full; m_active = 1; m_t = 0;
            end else if (m_t == FRAME - 1) begin
                comm = m_full; m_t = 0;
            end else begin
                m_t = m_t + 1;
            end
            if (comm) begin
                m_sd = m_pd; m_sdp = m_pdp; m_smk = m_pmk; m_full = 0;
            end else if (acc) begin
                m_pd = load_data; m_pdp = load_dp; m_pmk = load_mask; m_full = 1;
            end
        end
    end

    logic [14:0] obs_v, exp_v;
    assign obs_v = {an, seg, dp, frame_done, busy, load_ready};
    assign exp_v = {e_an, e_seg, e_dp, (en && m_active && m_t == FRAME - 1), m_active, !m_full};

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rstn = 0; en = 0; load_valid = 0; load_data = '0; load_dp = '0; load_mask = '0;
        cyc(3);
        n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an: got %b want 1111", an); end
        n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %h want 7f", seg); end
        n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b want 1", dp); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b want 0", frame_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", load_ready); end
        rstn = 1;
        cyc(1);
    endtask

    task automatic test_scan_unloaded;
        int seg0_cnt, an_lit, fd_cnt;
        seg0_cnt = 0; an_lit = 0; fd_cnt = 0;
        en = 1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc(1);
            n_checks++;
            if (obs_v !== exp_v) begin n_fail++; $display("FAIL scan_vec cyc %0d: got %h want %h", i, obs_v, exp_v); end
            if (seg === 7'h40) seg0_cnt++;
            if (an !== 4'hF) an_lit++;
            if (frame_done === 1'b1) fd_cnt++;
        end
        n_checks++; if (seg0_cnt != 8 * DRIVE_P) begin n_fail++; $display("FAIL scan_glyph0: got %0d want %0d", seg0_cnt, 8 * DRIVE_P); end
        n_checks++; if (an_lit != 0) begin n_fail++; $display("FAIL scan_mask0: got %0d lit cycles want 0", an_lit); end
        n_checks++; if (fd_cnt != 2) begin n_fail++; $display("FAIL scan_frames: got %0d want 2", fd_cnt); end
    endtask

    task automatic test_load_idle;
        int cnt [4];
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        en = 0;
        cyc(2);
        load_valid = 1; load_data = 16'h1A3F; load_mask = 4'hF; load_dp = 4'b0010;
        cyc(1);
        load_valid = 0;
        n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL idle_load_ready: got %b want 0", load_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
        en = 1;
        for (int i = 0; i < FRAME; i++) begin
            cyc(1);
            n_checks++;
            if (obs_v !== exp_v) begin n_fail++; $display("FAIL load_vec cyc %0d: got %h want %h", i, obs_v, exp_v); end
            case (an)
                4'b1110: begin cnt[0]++; n_checks++; if (seg !== 7'h0E || dp !== 1'b1) begin n_fail++; $display("FAIL dig0: got %h/%b want 0e/1", seg, dp); end end
                4'b1101: begin cnt[1]++; n_checks++; if (seg !== 7'h30 || dp !== 1'b0) begin n_fail++; $display("FAIL dig1: got %h/%b want 30/0", seg, dp); end end
                4'b1011: begin cnt[2]++; n_checks++; if (seg !== 7'h08 || dp !== 1'b1) begin n_fail++; $display("FAIL dig2: got %h/%b want 08/1", seg, dp); end end
                4'b0111: begin cnt[3]++; n_checks++; if (seg !== 7'h79 || dp !== 1'b1) begin n_fail++; $display("FAIL dig3: got %h/%b want 79/1", seg, dp); end end
                default: ;
            endcase
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (cnt[k] != DRIVE_P) begin n_fail++; $display("FAIL dig%0d_cycles: got %0d want %0d", k, cnt[k], DRIVE_P); end
        end
    endtask

    task automatic test_midframe_load;
        bit seen;
        int lit;
        cyc(20);
        load_valid = 1; load_data = 16'h2222; load_mask = 4'hF; load_dp = 4'h0;
        cyc(1);
        n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready_fall: got %b want 0", load_ready); end
        load_data = 16'h5555;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            n_checks++;
            if (obs_v !== exp_v) begin n_fail++; $display("FAIL mid_vec cyc %0d: got %h want %h", i, obs_v, exp_v); end
            if (an !== 4'hF) begin
                n_checks++;
                if (!(seg inside {7'h0E, 7'h30, 7'h08, 7'h79})) begin n_fail++; $display("FAIL mid_old_data: got %h want old glyph", seg); end
            end
        end
        load_valid = 0;
        seen = 0;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            cyc(1);
            if (frame_done === 1'b1) seen = 1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL mid_frame_done: got none want pulse"); end
        n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready_at_commit: got %b want 0", load_ready); end
        cyc(1);
        n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_rise: got %b want 1", load_ready); end
        lit = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (an !== 4'hF) begin
                lit++;
                n_checks++;
                if (seg !== 7'h24 || dp !== 1'b1) begin n_fail++; $display("FAIL mid_new_data: got %h/%b want 24/1", seg, dp); end
            end
            cyc(1);
        end
        n_checks++; if (lit != ND * DRIVE_P) begin n_fail++; $display("FAIL mid_lit_cycles: got %0d want %0d", lit, ND * DRIVE_P); end
    endtask

    task automatic test_en_drop;
        bit seen;
        int fd_cnt, wait_n, run;
        seen = 0;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            cyc(1);
            if (an === 4'b1011) seen = 1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL drop_find_dig2: got none want an=1011"); end
        en = 0;
        cyc(1);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy: got %b want 0", busy); end
        cyc(1);
        n_checks++; if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin n_fail++; $display("FAIL drop_dark: got %b/%h/%b want 1111/7f/1", an, seg, dp); end
        fd_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            cyc(1);
            if (frame_done !== 1'b0) fd_cnt++;
        end
        n_checks++; if (fd_cnt != 0) begin n_fail++; $display("FAIL drop_no_fd: got %0d want 0", fd_cnt); end
        en = 1;
        wait_n = 0;
        for (int i = 1; i <= 50 && wait_n == 0; i++) begin
            cyc(1);
            if (an === 4'b1110) wait_n = i;
        end
        n_checks++; if (wait_n != 2) begin n_fail++; $display("FAIL reen_latency: got %0d want 2", wait_n); end
        run = 0;
        while (an === 4'b1110 && run < 100) begin run++; cyc(1); end
        n_checks++; if (run != DRIVE_P) begin n_fail++; $display("FAIL reen_drive_len: got %0d want %0d", run, DRIVE_P); end
    endtask

    task automatic test_reset_midframe;
        int lit, seg0;
        load_valid = 1; load_data = 16'h7777; load_mask = 4'hF; load_dp = 4'hF;
        cyc(1);
        load_valid = 0;
        n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pending: got %b want 0", load_ready); end
        cyc(5);
        rstn = 0;
        cyc(1);
        n_checks++;
        if ({an, seg, dp, frame_done, busy, load_ready} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL rst_mid_outputs: got %h want %h", obs_v, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0, 1'b1});
        end
        rstn = 1;
        lit = 0; seg0 = 0;
        for (int i = 0; i < FRAME; i++) begin
            cyc(1);
            if (an !== 4'hF) lit++;
            if (seg === 7'h40) seg0++;
        end
        n_checks++; if (lit != 0) begin n_fail++; $display("FAIL rst_shadow_mask: got %0d lit want 0", lit); end
        n_checks++; if (seg0 != ND * DRIVE_P) begin n_fail++; $display("FAIL rst_shadow_data: got %0d want %0d", seg0, ND * DRIVE_P); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 3000; i++) begin
            cyc(1);
            n_checks++;
            if (obs_v !== exp_v) begin n_fail++; $display("FAIL rand_vec cyc %0d: got %h want %h", i, obs_v, exp_v); end
            rstn = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 149) == 0) en = ~en;
            if (!load_valid || $urandom_range(0, 3) == 0) begin
                load_valid = ($urandom_range(0, 7) == 0);
                load_data  = 16'($urandom);
                load_dp    = 4'($urandom);
                load_mask  = 4'($urandom);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_unloaded();
        test_load_idle();
        test_midframe_load();
        test_en_drop();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
